// File: rtl/button_pkg.sv
// ============================================================================
// button_pkg : shared button indices and per-channel FSM state type
// Revision   : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// btn_channel : synchronise, debounce and pulse/auto-repeat one button
// Revision    : 1.0
// ============================================================================
`default_nettype none

module btn_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_DELAY      = 25000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    input  logic repeat_en_i,
    output logic pulse_d_o,
    output logic stable_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(max_int(HOLD_DELAY, REPEAT_PERIOD));
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          flip;
    btn_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pulse_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = sync2_q;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts to the flip itself so the press pulse lands on the
    // same edge that raises the stable level.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        if (flip && !sync2_q) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flip && sync2_q) begin
                        pulse_d = 1'b1;
                        timer_d = HOLD_LOAD;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (repeat_en_i) begin
                        pulse_d = 1'b1;
                        timer_d = REP_LOAD;
                        state_d = REPEAT;
                    end
                end
                REPEAT: begin
                    if (!repeat_en_i) begin
                        timer_d = '0;
                        state_d = HOLD;
                    end else if (timer_q == '0) begin
                        pulse_d = 1'b1;
                        timer_d = REP_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
        end else begin
            sync1_q  <= btn_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    assign pulse_d_o = pulse_d;
    assign stable_o  = stable_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : four debounced buttons -> arbitrated one-cycle moves
// Revision           : 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_DELAY      = 25000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn_raw,
    input  logic       i_repeat_en,
    output logic       o_buffon_up,
    output logic       o_buffon_down,
    output logic       o_buffon_left,
    output logic       o_buffon_right,
    output logic [3:0] o_held
);

    logic [3:0] pulse_d;
    logic [3:0] stable;
    logic [3:0] buffon_d, buffon_q;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_DELAY      (HOLD_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_i       (i_clk),
            .rst_ni      (i_rst_n),
            .btn_raw_i   (i_btn_raw[g]),
            .repeat_en_i (i_repeat_en),
            .pulse_d_o   (pulse_d[g]),
            .stable_o    (stable[g])
        );
    end

    // Opposite moves cancel; the channel FSMs keep running regardless.
    always_comb begin
        buffon_d = pulse_d;
        if (pulse_d[BTN_UP] && pulse_d[BTN_DOWN]) begin
            buffon_d[BTN_UP]   = 1'b0;
            buffon_d[BTN_DOWN] = 1'b0;
        end
        if (pulse_d[BTN_LEFT] && pulse_d[BTN_RIGHT]) begin
            buffon_d[BTN_LEFT]  = 1'b0;
            buffon_d[BTN_RIGHT] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buffon_q <= '0;
        end else begin
            buffon_q <= buffon_d;
        end
    end

    assign o_buffon_up    = buffon_q[BTN_UP];
    assign o_buffon_down  = buffon_q[BTN_DOWN];
    assign o_buffon_left  = buffon_q[BTN_LEFT];
    assign o_buffon_right = buffon_q[BTN_RIGHT];
    assign o_held         = stable;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : directed + random bench with a behavioural model
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int HD   = 10;
    localparam int RP   = 5;
    localparam int MASK = (1 << DEB) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'b0;
    logic       en = 1'b1;
    logic       up, down, left, right;
    logic [3:0] held;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_DELAY      (HD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_btn_raw      (raw),
        .i_repeat_en    (en),
        .o_buffon_up    (up),
        .o_buffon_down  (down),
        .o_buffon_left  (left),
        .o_buffon_right (right),
        .o_held         (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: stable flips once the synchronised level has
    // disagreed with it for DEB consecutive samples; pulses follow elapsed
    // time since the last pulse.
    logic [3:0] m_r1, m_r2, m_stable, exp_buf, exp_held;
    int         m_hist[4];
    int         m_last[4];
    int         m_gap[4];
    bit         m_rep[4];
    int         m_tick;

    task automatic model_step();
        logic [3:0] p;
        logic       s;
        bit         flip;
        p = '0;
        if (!rst_n) begin
            m_r1 = '0; m_r2 = '0; m_stable = '0; m_tick = 0;
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = 0; m_last[b] = 0; m_gap[b] = 0; m_rep[b] = 0;
            end
        end else begin
            m_tick++;
            for (int b = 0; b < 4; b++) begin
                s = m_r2[b];
                m_hist[b] = ((m_hist[b] << 1) | int'(s)) & MASK;
                flip = (m_hist[b] == (m_stable[b] ? 0 : MASK));
                if (flip && s) begin
                    m_stable[b] = 1'b1;
                    p[b] = 1'b1;
                    m_last[b] = m_tick; m_gap[b] = HD; m_rep[b] = 0;
                end else if (flip) begin
                    m_stable[b] = 1'b0;
                end else if (m_stable[b]) begin
                    if (m_rep[b] && !en) begin
                        m_rep[b] = 0; m_gap[b] = 0;
                    end else if (en && (m_tick - m_last[b]) >= m_gap[b]) begin
                        p[b] = 1'b1;
                        m_last[b] = m_tick; m_gap[b] = RP; m_rep[b] = 1;
                    end
                end
            end
            m_r2 = m_r1;
            m_r1 = raw;
            if (p[0] && p[1]) p[1:0] = 2'b00;
            if (p[2] && p[3]) p[3:2] = 2'b00;
        end
        exp_buf  = p;
        exp_held = m_stable;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_buffon", int'({right, left, down, up}), 0);
                chk("rst_held", int'(held), 0);
            end else begin
                chk("model_buffon", int'({right, left, down, up}), int'(exp_buf));
                chk("model_held", int'(held), int'(exp_held));
            end
        end
    end

    // Directed scenario recording: pl = edges with the watched bit pulsing,
    // po = edges with any other bit pulsing, relative to the press.
    int         pl[$];
    int         po[$];
    int         eq[$];
    logic [3:0] held5, held6;

    task automatic scenario(input logic [3:0] mask, input int hold, input int total,
                            input logic en_init, input int en_at, input int idx);
        logic [3:0] o;
        pl.delete(); po.delete();
        @(negedge clk);
        raw = mask;
        en  = en_init;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            o = {right, left, down, up};
            if (o[idx]) pl.push_back(i);
            if ((o & ~(4'b1 << idx)) != 4'b0) po.push_back(i);
            if (i == 5) held5 = held;
            if (i == 6) held6 = held;
            if (i == hold) raw = 4'b0;
            if (i == en_at) en = 1'b1;
        end
    endtask

    task automatic check_list(input string name);
        chk({name, "_count"}, pl.size(), eq.size());
        for (int k = 0; k < eq.size(); k++)
            chk({name, "_edge"}, (k < pl.size()) ? pl[k] : -1, eq[k]);
    endtask

    initial begin
        int glitch_pulses;
        int glitch_held;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({right, left, down, up, held}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        scenario(4'b0001, 8, 20, 1'b1, 0, 0);
        eq = '{6};
        check_list("up_press");
        chk("up_other_pulses", po.size(), 0);
        chk("up_held_edge5", int'(held5[0]), 0);
        chk("up_held_edge6", int'(held6[0]), 1);

        glitch_pulses = 0;
        glitch_held   = 0;
        for (int r = 0; r < 5; r++) begin
            raw = 4'b0100;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (c == 2) raw = 4'b0000;
                if (left) glitch_pulses++;
                if (held[2]) glitch_held++;
            end
        end
        chk("glitch_left_pulses", glitch_pulses, 0);
        chk("glitch_left_held", glitch_held, 0);
        repeat (8) @(negedge clk);

        scenario(4'b1000, 40, 52, 1'b1, 0, 3);
        eq = '{6, 16, 21, 26, 31, 36, 41};
        check_list("right_repeat");

        scenario(4'b1000, 40, 52, 1'b0, 25, 3);
        eq = '{6, 26, 31, 36, 41};
        check_list("right_late_enable");

        scenario(4'b0011, 10, 22, 1'b1, 0, 0);
        eq = '{};
        check_list("updown_up");
        chk("updown_down_pulses", po.size(), 0);
        chk("updown_held", int'(held6), 3);

        scenario(4'b0101, 8, 20, 1'b1, 0, 0);
        eq = '{6};
        check_list("upleft_up");
        chk("upleft_left_count", po.size(), 1);
        chk("upleft_left_edge", (po.size() > 0) ? po[0] : -1, 6);

        raw = 4'b0010;
        repeat (12) @(negedge clk);
        chk("midhold_held_before", int'(held), 2);
        rst_n = 1'b0;
        #1;
        chk("midhold_async_held", int'(held), 0);
        chk("midhold_async_buffon", int'({right, left, down, up}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pl.delete();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (down) pl.push_back(i);
        end
        eq = '{6};
        check_list("reset_rehold");
        raw = 4'b0;
        repeat (10) @(negedge clk);

        for (int it = 0; it < 250; it++) begin
            raw = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        raw = 4'b0;
        en  = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the four raw push-buttons for the pattern/rectangle data generator.
- Per button: synchronises, debounces and converts into single-cycle move pulses, with optional auto-repeat while held.
- Outputs drive the generator's up/down/left/right button inputs directly, so one pulse equals one pixel step.
- Sits between the board pins and the data generator, in the same clock domain as the pixel counter.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronised input must differ from the stable level before the stable level flips (10 ms at 50 MHz); minimum 2.
- HOLD_DELAY, 25000000, cycles from the press pulse to the first repeat pulse; minimum 2.
- REPEAT_PERIOD, 2500000, cycles between successive repeat pulses; minimum 2.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_btn_raw  in  4  raw pins, bit0=up, bit1=down, bit2=left, bit3=right, active-high, asynchronous
- i_repeat_en  in  1  1 = auto-repeat enabled; sampled every cycle
- o_buffon_up  out  1  one-cycle move pulse
- o_buffon_down  out  1  one-cycle move pulse
- o_buffon_left  out  1  one-cycle move pulse
- o_buffon_right  out  1  one-cycle move pulse
- o_held  out  4  debounced stable levels, same bit order as i_btn_raw

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Synchroniser flops, stable levels, counters and FSMs all clear to 0 / IDLE.
  - All o_buffon_* = 0 and o_held = 0.
- Synchroniser: two flops per bit. s = second flop.
- Debounce, per bit:
  - cnt clears whenever s == stable.
  - Otherwise cnt increments.
  - When s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s and cnt <= 0.
  - Widths: $clog2 of each parameter; no wrap is possible.
- Latency: a clean rise of the raw input between edge 0 and edge 1 sets stable at edge DEBOUNCE_CYCLES+2. The press pulse is registered on that same edge.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Per-button FSM (registered pulse raw_p):
  - IDLE: on a stable 0->1 edge, raw_p=1 for one cycle, load timer with HOLD_DELAY-1, go HOLD.
  - HOLD: timer decrements each cycle.
    - At 0 with i_repeat_en=1: raw_p=1, load REPEAT_PERIOD-1, go REPEAT.
    - At 0 with i_repeat_en=0: stay in HOLD with the timer held at 0, no pulse.
  - REPEAT: timer decrements; at 0, raw_p=1 and reload REPEAT_PERIOD-1. If i_repeat_en=0, go HOLD with the timer at 0 (no pulse).
  - Any state: stable 1->0 forces IDLE and clears the timer. No pulse on release.
- Pulse timing, with press pulse at edge P: repeats at P+HOLD_DELAY, then P+HOLD_DELAY+k*REPEAT_PERIOD.
- Opposite-direction arbitration (registered with the pulses):
  - raw_p up and down both 1 in the same cycle -> o_buffon_up = o_buffon_down = 0 that cycle; same rule for left/right.
  - Non-opposite pairs (e.g. up+left) pass together.
  - Suppression does not alter either FSM.
- o_held = stable, registered.
- Every o_buffon_* pulse is exactly one cycle wide.
- Reset released while a button is held: stable starts at 0, so the button re-debounces and produces a fresh press pulse DEBOUNCE_CYCLES+2 edges after release of reset.
- Reset asserted mid-hold: all outputs drop immediately (asynchronously).

Decomposition:
- Shared package button_pkg holds:
  - Bit-index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3.
  - FSM state typedef {IDLE, HOLD, REPEAT}.
- One sub-module, btn_channel: synchroniser, debounce and FSM for one bit. Instantiated four times.
- Top level holds the arbitration and output registers.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_DELAY=10, REPEAT_PERIOD=5):
- Clean press of up, raw rises before edge 1, held 8 cycles -> o_buffon_up single pulse after edge 6; o_held[0]=1 from edge 6; no other pulses.
- Raw left toggles high 3 cycles then low, repeated 5 times -> o_buffon_left and o_held[2] stay 0 throughout.
- Right held 40 cycles with i_repeat_en=1 -> pulses after edges 6, 16, 21, 26, 31, 36, 41 (41 only if still held); release gives no pulse.
- Same hold with i_repeat_en=0 -> only the edge-6 pulse. Raising i_repeat_en at edge 25 -> next pulse at edge 26, then every 5 cycles.
- Up and down pressed on the same cycle -> both outputs stay 0 at edge 6, o_held=4'b0011. Up+left pressed together -> both pulse at edge 6.
- Hold down, assert i_rst_n low mid-HOLD for 3 cycles, release with button still high -> outputs 0 during reset; new press pulse DEBOUNCE_CYCLES+2 = 6 edges after reset release.
